// File: rtl/sdft_sequencer.sv
// Sequences ADC samples into a sliding DFT, reads bins back and writes magnitudes.
// Optional peak tracking is compiled in with SDFT_SEQ_PEAK_EN.
module sdft_sequencer #(
   parameter int DATA_W     = 8,
   parameter int FREQ_W     = 16,
   parameter int BINS       = 32,
   parameter int BIN_ADDR_W = 5,
   parameter int SAMPLE_DIV = 64,
   parameter int READ_EVERY = 128,
   parameter int MAG_SHIFT  = 8,
   parameter int TIMEOUT    = 1023
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         enable,
   input  logic        [DATA_W-1:0]     adc,
   output logic        [DATA_W-1:0]     sdft_sample,
   output logic                         sdft_start,
   input  logic                         sdft_ready,
   output logic                         sdft_read,
   output logic        [BIN_ADDR_W-1:0] sdft_bin_addr,
   input  logic signed [FREQ_W-1:0]     bin_real,
   input  logic signed [FREQ_W-1:0]     bin_imag,
   output logic                         bram_w_en,
   output logic        [BIN_ADDR_W-1:0] bram_w_addr,
   output logic        [FREQ_W-1:0]     bram_d_in,
   output logic                         frame_done,
   output logic                         overrun,
   output logic                         timeout_err,
   output logic        [BIN_ADDR_W-1:0] peak_bin,
   output logic        [FREQ_W-1:0]     peak_mag
);

   localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int SCNT_W = (READ_EVERY > 1) ? $clog2(READ_EVERY) : 1;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam int SUM_W  = 2 * FREQ_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_PROCESS,
      S_READ,
      S_CAPTURE,
      S_MAG,
      S_WRITE
   } state_t;

   state_t                     state;
   state_t                     state_nx;
   logic [TICK_W-1:0]          tick_cnt;
   logic [SCNT_W-1:0]          smp_cnt;
   logic [WAIT_W-1:0]          wait_cnt;
   logic signed [FREQ_W-1:0]   re_q;
   logic signed [FREQ_W-1:0]   im_q;
   logic signed [2*FREQ_W-1:0] re_sq;
   logic signed [2*FREQ_W-1:0] im_sq;
   logic [SUM_W-1:0]           sum;
   logic [SUM_W-1:0]           shifted;
   logic [FREQ_W-1:0]          mag;
   logic                       tick;
   logic                       accept;
   logic                       last_smp;
   logic                       last_bin;
   logic                       stalled;
   logic                       timeout_hit;

   assign tick     = enable && (tick_cnt == TICK_W'(SAMPLE_DIV - 1));
   assign accept   = (state == S_IDLE) && tick && sdft_ready;
   assign last_smp = (smp_cnt == SCNT_W'(READ_EVERY - 1));
   assign last_bin = (sdft_bin_addr == BIN_ADDR_W'(BINS - 1));

   // Handshake is stuck when the SDFT has not yet answered in the waiting state.
   assign stalled = ((state == S_START) && sdft_ready)
                 || ((state == S_PROCESS) && !sdft_ready);
   assign timeout_hit = stalled && (wait_cnt == WAIT_W'(TIMEOUT));

   assign sdft_start  = (state == S_START);
   assign sdft_read   = (state == S_READ);
   assign bram_w_en   = (state == S_WRITE);
   assign bram_w_addr = sdft_bin_addr;
   assign frame_done  = bram_w_en && last_bin;

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:    if (accept) state_nx = S_START;
         S_START: begin
            if (!sdft_ready)      state_nx = S_PROCESS;
            else if (timeout_hit) state_nx = S_IDLE;
         end
         S_PROCESS: begin
            if (sdft_ready)       state_nx = last_smp ? S_READ : S_IDLE;
            else if (timeout_hit) state_nx = S_IDLE;
         end
         S_READ:    state_nx = S_CAPTURE;
         S_CAPTURE: state_nx = S_MAG;
         S_MAG:     state_nx = S_WRITE;
         S_WRITE:   state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // Full-width power sum, then shift and clamp into the magnitude width.
   always_comb begin
      re_sq   = re_q * re_q;
      im_sq   = im_q * im_q;
      sum     = {1'b0, re_sq} + {1'b0, im_sq};
      shifted = sum >> MAG_SHIFT;
      mag     = (|shifted[SUM_W-1:FREQ_W]) ? '1 : shifted[FREQ_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         tick_cnt      <= '0;
         smp_cnt       <= '0;
         wait_cnt      <= '0;
         sdft_sample   <= '0;
         sdft_bin_addr <= '0;
         re_q          <= '0;
         im_q          <= '0;
         bram_d_in     <= '0;
         overrun       <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         state    <= state_nx;
         tick_cnt <= (!enable || tick) ? '0 : tick_cnt + 1'b1;

         if (state_nx != state)
            wait_cnt <= '0;
         else if ((state == S_START) || (state == S_PROCESS))
            wait_cnt <= wait_cnt + 1'b1;

         if (accept)
            sdft_sample <= adc;
         if (tick && !accept)
            overrun <= 1'b1;
         if (timeout_hit)
            timeout_err <= 1'b1;

         if ((state == S_PROCESS) && sdft_ready)
            smp_cnt <= last_smp ? '0 : smp_cnt + 1'b1;

         if (state == S_CAPTURE) begin
            re_q <= bin_real;
            im_q <= bin_imag;
         end
         if (state == S_MAG)
            bram_d_in <= mag;
         if (state == S_WRITE)
            sdft_bin_addr <= last_bin ? '0 : sdft_bin_addr + 1'b1;
      end
   end

`ifdef SDFT_SEQ_PEAK_EN
   logic [FREQ_W-1:0]     run_mag;
   logic [BIN_ADDR_W-1:0] run_bin;
   logic                  new_max;

   // Strict compare so a tie keeps the earlier (lower) bin.
   assign new_max = bram_d_in > run_mag;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         run_mag  <= '0;
         run_bin  <= '0;
         peak_mag <= '0;
         peak_bin <= '0;
      end else if (bram_w_en) begin
         if (frame_done) begin
            peak_mag <= new_max ? bram_d_in : run_mag;
            peak_bin <= new_max ? sdft_bin_addr : run_bin;
            run_mag  <= '0;
            run_bin  <= '0;
         end else if (new_max) begin
            run_mag <= bram_d_in;
            run_bin <= sdft_bin_addr;
         end
      end
   end
`else
   assign peak_bin = '0;
   assign peak_mag = '0;
`endif

endmodule

// File: tb/tb_sdft_sequencer.sv
// Scoreboard bench for sdft_sequencer: SDFT model, write checks, timeout and reset.
// Peak expectations follow SDFT_SEQ_PEAK_EN.
module tb_sdft_sequencer;

   localparam int DATA_W = 8;
   localparam int FREQ_W = 16;
   localparam int BINS   = 4;
   localparam int BAW    = 2;

`ifdef SDFT_SEQ_PEAK_EN
   localparam bit PK = 1'b1;
`else
   localparam bit PK = 1'b0;
`endif

   typedef enum int {M_NORMAL, M_STUCK, M_HOLD} mode_t;

   typedef struct {
      int addr;
      int data;
      bit frame;
      int cyc;
      int pbin;
      int pmag;
   } exp_t;

   logic                     clk;
   logic                     reset_n;
   logic                     enable;
   logic        [DATA_W-1:0] adc;
   logic        [DATA_W-1:0] sdft_sample;
   logic                     sdft_start;
   logic                     sdft_ready;
   logic                     sdft_read;
   logic        [BAW-1:0]    sdft_bin_addr;
   logic signed [FREQ_W-1:0] bin_real;
   logic signed [FREQ_W-1:0] bin_imag;
   logic                     bram_w_en;
   logic        [BAW-1:0]    bram_w_addr;
   logic        [FREQ_W-1:0] bram_d_in;
   logic                     frame_done;
   logic                     overrun;
   logic                     timeout_err;
   logic        [BAW-1:0]    peak_bin;
   logic        [FREQ_W-1:0] peak_mag;

   sdft_sequencer #(
      .DATA_W(DATA_W), .FREQ_W(FREQ_W), .BINS(BINS), .BIN_ADDR_W(BAW),
      .SAMPLE_DIV(16), .READ_EVERY(2), .MAG_SHIFT(8), .TIMEOUT(1023)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .adc(adc),
      .sdft_sample(sdft_sample), .sdft_start(sdft_start),
      .sdft_ready(sdft_ready), .sdft_read(sdft_read),
      .sdft_bin_addr(sdft_bin_addr), .bin_real(bin_real),
      .bin_imag(bin_imag), .bram_w_en(bram_w_en),
      .bram_w_addr(bram_w_addr), .bram_d_in(bram_d_in),
      .frame_done(frame_done), .overrun(overrun),
      .timeout_err(timeout_err), .peak_bin(peak_bin), .peak_mag(peak_mag)
   );

   // Hand-computed bin data and (re^2+im^2)>>8, clamped to 65535.
   int re_tab[10]  = '{300, -32768, 36, 48, 36, 48, 0, 23, 0, 300};
   int im_tab[10]  = '{-400, -32768, 0, 0, 0, 0, 48, 0, 0, -400};
   int mag_tab[10] = '{976, 65535, 5, 9, 5, 9, 9, 2, 0, 976};
   int pkb_tab[10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
   int pkm_tab[10] = '{0, 0, 0, 65535, 0, 0, 0, 9, 0, 0};

   exp_t  sb[$];
   exp_t  pk_exp;
   mode_t mode;
   bit    pk_pend;
   bit    busy;
   int    bcnt;
   int    rd_idx;
   int    exp_addr;
   int    n_checks;
   int    n_err;
   int    n_starts;
   int    n_reads;
   int    n_writes;
   int    viol;
   int    cyc;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SDFT model: drops ready the cycle start is seen, returns it 3 cycles later.
   always @(negedge clk) begin
      if (!reset_n) begin
         busy       = 1'b0;
         sdft_ready = 1'b1;
         exp_addr   = 0;
      end else begin
         if (mode == M_HOLD) begin
            busy       = 1'b0;
            sdft_ready = 1'b1;
         end else if (sdft_start && !busy) begin
            check("sample_latch", sdft_sample, adc);
            n_starts++;
            sdft_ready = 1'b0;
            busy       = 1'b1;
            bcnt       = 3;
            adc        = adc + 8'd37;
         end else if (busy && (mode == M_NORMAL)) begin
            bcnt--;
            if (bcnt == 0) begin
               sdft_ready = 1'b1;
               busy       = 1'b0;
            end
         end
         if (sdft_read) begin
            exp_t e;
            bin_real = 16'(re_tab[rd_idx]);
            bin_imag = 16'(im_tab[rd_idx]);
            e.addr  = exp_addr;
            e.data  = mag_tab[rd_idx];
            e.frame = (exp_addr == BINS - 1);
            e.cyc   = cyc + 3;
            e.pbin  = PK ? pkb_tab[rd_idx] : 0;
            e.pmag  = PK ? pkm_tab[rd_idx] : 0;
            sb.push_back(e);
            exp_addr = (exp_addr + 1) % BINS;
            rd_idx++;
            n_reads++;
         end
      end
   end

   // Monitor: pops expectations whenever a magnitude write appears.
   always @(negedge clk) begin
      if (pk_pend) begin
         check("peak_bin", peak_bin, pk_exp.pbin);
         check("peak_mag", peak_mag, pk_exp.pmag);
         pk_pend = 1'b0;
      end
      if ((int'(sdft_start) + int'(sdft_read) + int'(bram_w_en)) > 1)
         viol++;
      if (frame_done && !bram_w_en)
         viol++;
      if (bram_w_en) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0d, expected no write",
                     bram_w_addr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("wr_addr", bram_w_addr, e.addr);
            check("wr_data", bram_d_in, e.data);
            check("frame_done", frame_done, e.frame);
            check("wr_latency", cyc, e.cyc);
            n_writes++;
            if (e.frame) begin
               pk_exp  = e;
               pk_pend = 1'b1;
            end
         end
      end
   end

   initial begin
      bit ok;
      n_checks = 0;
      n_err    = 0;
      n_starts = 0;
      n_reads  = 0;
      n_writes = 0;
      viol     = 0;
      rd_idx   = 0;
      pk_pend  = 1'b0;
      mode     = M_NORMAL;
      reset_n  = 1'b0;
      enable   = 1'b0;
      adc      = 8'h5A;
      bin_real = '0;
      bin_imag = '0;
      sdft_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_start", sdft_start, 0);
      check("rst_read", sdft_read, 0);
      check("rst_wen", bram_w_en, 0);
      check("rst_frame", frame_done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_sample", sdft_sample, 0);
      check("rst_addr", sdft_bin_addr, 0);
      check("rst_data", bram_d_in, 0);
      check("rst_peak", {peak_bin, peak_mag}, 0);

      @(posedge clk);
      #1;
      reset_n = 1'b1;
      enable  = 1'b1;

      for (int i = 0; i < 1000 && n_writes < 9; i++) @(posedge clk);
      @(negedge clk);
      check("writes_run1", n_writes, 9);
      check("starts_run1", n_starts, 18);
      check("reads_run1", n_reads, 9);
      check("no_overrun", overrun, 0);
      check("no_timeout", timeout_err, 0);

      // Stall the SDFT in PROCESS and measure the timeout.
      @(posedge clk);
      #1;
      mode = M_STUCK;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = sdft_start;
      end
      check("stuck_start_seen", ok, 1);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = !sdft_start;
      end
      check("stuck_start_drop", ok, 1);
      repeat (1023) @(negedge clk);
      check("timeout_before", timeout_err, 0);
      @(negedge clk);
      check("timeout_set", timeout_err, 1);
      check("timeout_start", sdft_start, 0);
      check("timeout_overrun", overrun, 1);
      check("timeout_addr", sdft_bin_addr, 1);

      // Reset while START is held.
      @(posedge clk);
      #1;
      mode = M_HOLD;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = sdft_start;
      end
      check("hold_start_seen", ok, 1);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_start", sdft_start, 0);
      check("mid_rst_overrun", overrun, 0);
      check("mid_rst_timeout", timeout_err, 0);
      check("mid_rst_addr", sdft_bin_addr, 0);
      check("mid_rst_sample", sdft_sample, 0);
      check("mid_rst_data", bram_d_in, 0);
      mode = M_NORMAL;
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      for (int i = 0; i < 200 && n_writes < 10; i++) @(posedge clk);
      repeat (4) @(negedge clk);
      check("writes_after_rst", n_writes, 10);
      check("sb_empty", sb.size(), 0);
      check("strobe_violations", viol, 0);
      check("final_overrun", overrun, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
